// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch resolve controller.
// Controller state, queue entry layout, default queue depth.
package branch_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int BRC_DEFAULT_DEPTH = 4;

  typedef enum logic [0:0] {
    BRC_RUN,
    BRC_RECOVER
  } brc_state_t;

  typedef struct packed {
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] fallthru;
  } brc_entry_t;

endpackage

// File: rtl/brc_fifo.sv
// Circular queue of in-flight predicted branches.
// Clear empties the queue and wins over a same-cycle push.
module brc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                       clk,
  input  logic                       rstn_h,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; count guards every read.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: queues predictions, checks them at execute.
// Optional BRC_PERF_CNT_EN adds resolved/mispredict counters.
module branch_resolve_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int DEPTH        = BRC_DEFAULT_DEPTH,
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rstn_h,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic                     pred_taken,
  input  logic [ADDR_W-1:0]        pred_target,
  input  logic [ADDR_W-1:0]        pred_fallthru,
  input  logic                     resolve_valid,
  input  logic                     act_taken,
  input  logic [ADDR_W-1:0]        act_target,
  output logic                     flush,
  output logic [ADDR_W-1:0]        redirect_pc,
  output logic                     upd_valid,
  output logic                     upd_act_taken,
  output logic                     upd_pred_taken,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_underflow
`ifdef BRC_PERF_CNT_EN
  ,
  output logic [31:0]              perf_resolved,
  output logic [31:0]              perf_mispred
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(FLUSH_CYCLES + 1);

  typedef struct packed {
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] fallthru;
  } entry_t;

  localparam int EW = $bits(entry_t);

  brc_state_t  state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  entry_t        wr_ent, head;
  logic [CW-1:0] cnt;
  logic          push, pop, mispred;

  logic              flush_q;
  logic [ADDR_W-1:0] rpc_q;
  logic              uv_q, ua_q, up_q;
  logic              err_q;

  assign pred_ready = (state_q == BRC_RUN) && (cnt < CW'(DEPTH));
  assign push       = pred_valid && pred_ready;
  assign pop        = resolve_valid && (cnt != '0);

  assign wr_ent = '{taken: pred_taken,
                    target: pred_target,
                    fallthru: pred_fallthru};

  assign mispred = pop &&
    ((head.taken != act_taken) ||
     (act_taken && (head.target != act_target)));

  brc_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rstn_h  (rstn_h),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (mispred),
    .wdata_i (wr_ent),
    .rdata_o (head),
    .count_o (cnt)
  );

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      BRC_RUN: begin
        if (mispred) begin
          state_d = BRC_RECOVER;
          rcnt_d  = RW'(FLUSH_CYCLES);
        end
      end
      BRC_RECOVER: begin
        if (rcnt_q <= RW'(1)) begin
          state_d = BRC_RUN;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q - RW'(1);
        end
      end
      default: begin
        state_d = BRC_RUN;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      state_q <= BRC_RUN;
      rcnt_q  <= '0;
      flush_q <= 1'b0;
      rpc_q   <= '0;
      uv_q    <= 1'b0;
      ua_q    <= 1'b0;
      up_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      flush_q <= mispred;
      uv_q    <= pop;
      if (mispred)
        rpc_q <= act_taken ? act_target : head.fallthru;
      if (pop) begin
        ua_q <= act_taken;
        up_q <= head.taken;
      end
      if (resolve_valid && (cnt == '0))
        err_q <= 1'b1;
    end
  end

  assign flush          = flush_q;
  assign redirect_pc    = rpc_q;
  assign upd_valid      = uv_q;
  assign upd_act_taken  = ua_q;
  assign upd_pred_taken = up_q;
  assign count          = cnt;
  assign err_underflow  = err_q;

`ifdef BRC_PERF_CNT_EN
  logic [31:0] pres_q, pmis_q;

  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      pres_q <= '0;
      pmis_q <= '0;
    end else begin
      if (pop && (pres_q != '1))     pres_q <= pres_q + 32'd1;
      if (mispred && (pmis_q != '1)) pmis_q <= pmis_q + 32'd1;
    end
  end

  assign perf_resolved = pres_q;
  assign perf_mispred  = pmis_q;
`endif

endmodule
